// File: rtl/prog_tt_pkg.sv
// rtl/prog_tt_pkg.sv - shared types, sizes and default table for prog_truth_table
package prog_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } tt_state_e;

    // Sizes for the default build (N_IN = 3, N_CH = 1); parameterised
    // instances size themselves with tt_depth / tt_tbl_w.
    localparam int N_IN_DEF = 3;
    localparam int N_CH_DEF = 1;
    localparam int DEPTH    = 2 ** N_IN_DEF;
    localparam int TBL_W    = N_CH_DEF * DEPTH;

    // Per-channel byte replicated into the reset table (minterms 0, 2, 6).
    localparam logic [7:0] TT_DEFAULT_BYTE = 8'h45;

    // Widest table the default-table builder can produce (N_CH * 64 bits max).
    localparam int TBL_MAX_W = 1024;

    function automatic int tt_depth(input int n_in);
        return 2 ** n_in;
    endfunction

    function automatic int tt_tbl_w(input int n_in, input int n_ch);
        return n_ch * (2 ** n_in);
    endfunction

    // {n_ch{8'h45}} zero-extended to TBL_MAX_W; callers cast down to their
    // own table width, which truncates or leaves the upper bits zero.
    function automatic logic [TBL_MAX_W-1:0] default_table(input int n_ch);
        logic [TBL_MAX_W-1:0] t;
        t = '0;
        for (int i = 0; i < n_ch; i++) begin
            if ((i + 1) * 8 <= TBL_MAX_W) begin
                t[i*8 +: 8] = TT_DEFAULT_BYTE;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/tt_shift_loader.sv
// rtl/tt_shift_loader.sv - serial shadow-table loader with commit strobe
module tt_shift_loader
    import prog_tt_pkg::*;
#(
    parameter int               TABLE_W = TBL_W,
    parameter logic [TABLE_W-1:0] INIT  = TABLE_W'(default_table(N_CH_DEF))
) (
    input  logic               clk,        // rising-edge clock
    input  logic               rst,        // synchronous, active-high
    input  logic               cfg_start,  // begin or restart a load
    input  logic               cfg_valid,  // cfg_bit present this cycle
    input  logic               cfg_bit,    // serial table bit, index 0 first
    output logic [TABLE_W-1:0] shadow,     // table being assembled
    output logic               cfg_busy,   // load in progress
    output logic               cfg_done    // one-cycle commit strobe
);

    localparam int IDX_W = (TABLE_W > 1) ? $clog2(TABLE_W) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TABLE_W - 1);

    tt_state_e        state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            shadow   <= INIT;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state    <= ST_LOAD;
                        count    <= '0;
                        cfg_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // A restart only rewinds the counter: a commit needs every
                    // index rewritten, so stale shadow bits can never leak out.
                    if (cfg_start) begin
                        count <= '0;
                    end else if (cfg_valid) begin
                        shadow[count[IDX_W-1:0]] <= cfg_bit;
                        if (count == LAST_IDX) begin
                            state    <= ST_COMMIT;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    // cfg_done is high throughout this state; the top copies
                    // shadow into the active table on the edge that leaves it.
                    if (cfg_start) begin
                        state    <= ST_LOAD;
                        count    <= '0;
                        cfg_busy <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    count    <= '0;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/prog_truth_table.sv
// rtl/prog_truth_table.sv - runtime-programmable registered truth-table evaluator
module prog_truth_table
    import prog_tt_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int N_CH = 1,
    parameter logic [N_CH*(2**N_IN)-1:0] INIT = (N_CH*(2**N_IN))'(default_table(N_CH))
) (
    input  logic            clk,        // rising-edge clock
    input  logic            rst,        // synchronous, active-high
    input  logic            in_valid,   // evaluation request
    input  logic [N_IN-1:0] in_vec,     // minterm index, MSB is input A
    output logic            out_valid,  // result valid one cycle after in_valid
    output logic [N_CH-1:0] f,          // per-channel results
    input  logic            cfg_start,  // begin or restart a table load
    input  logic            cfg_valid,  // cfg_bit present this cycle
    input  logic            cfg_bit,    // serial table bit
    output logic            cfg_busy,   // load in progress
    output logic            cfg_done    // new table committed
);

    localparam int ROW_W   = tt_depth(N_IN);
    localparam int TABLE_W = tt_tbl_w(N_IN, N_CH);

    logic [TABLE_W-1:0] active;
    logic [TABLE_W-1:0] shadow;
    logic [ROW_W-1:0]   row_sel;
    logic [N_CH-1:0]    f_next;

    tt_shift_loader #(
        .TABLE_W (TABLE_W),
        .INIT    (INIT)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .shadow    (shadow),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done)
    );

    // Indexing each row with in_vec directly keeps an unknown in_vec
    // propagating as X to the result in simulation.
    always_comb begin
        f_next  = '0;
        row_sel = '0;
        for (int k = 0; k < N_CH; k++) begin
            row_sel   = active[k*ROW_W +: ROW_W];
            f_next[k] = row_sel[in_vec];
        end
    end

    // The commit and an evaluation on the same edge both read the pre-edge
    // active table, so that request sees the old function.
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= INIT;
            out_valid <= 1'b0;
            f         <= '0;
        end else begin
            if (cfg_done) begin
                active <= shadow;
            end
            out_valid <= in_valid;
            if (in_valid) begin
                f <= f_next;
            end
        end
    end

endmodule

// File: tb/tb_prog_truth_table.sv
// tb/tb_prog_truth_table.sv - scoreboard bench for prog_truth_table
module tb_prog_truth_table;

    logic       clk;
    logic       rst;
    logic       in_valid, cfg_start, cfg_valid, cfg_bit;
    logic [2:0] in_vec;
    logic [0:0] f;
    logic       out_valid, cfg_busy, cfg_done;

    logic       in_valid2, cfg_start2, cfg_valid2, cfg_bit2;
    logic [1:0] in_vec2;
    logic [1:0] f2;
    logic       out_valid2, cfg_busy2, cfg_done2;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] tbl;
    logic [7:0] tbl2;
    logic       q[$];
    logic [1:0] q2[$];

    prog_truth_table #(.N_IN(3), .N_CH(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
        .out_valid(out_valid), .f(f), .cfg_start(cfg_start),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done)
    );

    prog_truth_table #(.N_IN(2), .N_CH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_vec(in_vec2),
        .out_valid(out_valid2), .f(f2), .cfg_start(cfg_start2),
        .cfg_valid(cfg_valid2), .cfg_bit(cfg_bit2), .cfg_busy(cfg_busy2),
        .cfg_done(cfg_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++; if (f !== 1'b0)        begin n_miss++; $display("FAIL reset_f got %b want 0", f); end
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (cfg_busy !== 1'b0)  begin n_miss++; $display("FAIL reset_cfg_busy got %b want 0", cfg_busy); end
        n_vec++; if (cfg_done !== 1'b0)  begin n_miss++; $display("FAIL reset_cfg_done got %b want 0", cfg_done); end
        n_vec++; if (f2 !== 2'b00)       begin n_miss++; $display("FAIL reset_f2 got %b want 00", f2); end
        rst  = 1'b0;
        tbl  = 8'h45;
        tbl2 = 8'h45;
        q.delete();
        q2.delete();
    endtask

    task automatic test_sweep(input string tag);
        logic e;
        for (int v = 0; v < 8; v++) begin
            in_valid = 1'b1;
            in_vec   = 3'(v);
            q.push_back(tbl[v]);
            step();
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_miss++; $display("FAIL %s_out_valid v=%0d got %b want 1", tag, v, out_valid);
            end
            if (q.size() == 0) begin
                n_vec++; n_miss++; $display("FAIL %s_queue v=%0d got empty want entry", tag, v);
            end else begin
                e = q.pop_front();
                n_vec++;
                if (f !== e) begin
                    n_miss++; $display("FAIL %s_f v=%0d got %b want %b", tag, v, f, e);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++; $display("FAIL %s_idle_out_valid got %b want 0", tag, out_valid);
        end
    endtask

    // Loads bits (index 0 first) with random gaps, probing in_vec=probe on
    // the commit edge (old table expected) and on the following edge (new).
    task automatic load_table(input logic [7:0] bits, input logic [2:0] probe, input string tag);
        int   pulses;
        int   gaps;
        logic e;
        pulses    = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        n_vec++;
        if (cfg_busy !== 1'b1) begin
            n_miss++; $display("FAIL %s_busy_after_start got %b want 1", tag, cfg_busy);
        end
        for (int i = 0; i < 8; i++) begin
            gaps = int'($urandom_range(0, 2));
            repeat (gaps) begin
                cfg_valid = 1'b0;
                cfg_bit   = $urandom_range(0, 1) != 0;
                step();
                if (cfg_done === 1'b1) pulses++;
            end
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            step();
            if (cfg_done === 1'b1) pulses++;
        end
        cfg_valid = 1'b0;
        n_vec++;
        if (cfg_done !== 1'b1) begin
            n_miss++; $display("FAIL %s_done_after_last got %b want 1", tag, cfg_done);
        end
        n_vec++;
        if (cfg_busy !== 1'b0) begin
            n_miss++; $display("FAIL %s_busy_in_commit got %b want 0", tag, cfg_busy);
        end
        in_valid = 1'b1;
        in_vec   = probe;
        q.push_back(tbl[probe]);
        step();
        if (cfg_done === 1'b1) pulses++;
        e = q.pop_front();
        n_vec++;
        if (f !== e) begin
            n_miss++; $display("FAIL %s_commit_edge_f got %b want %b", tag, f, e);
        end
        tbl = bits;
        q.push_back(tbl[probe]);
        step();
        if (cfg_done === 1'b1) pulses++;
        in_valid = 1'b0;
        e = q.pop_front();
        n_vec++;
        if (f !== e) begin
            n_miss++; $display("FAIL %s_after_commit_f got %b want %b", tag, f, e);
        end
        n_vec++;
        if (pulses != 1) begin
            n_miss++; $display("FAIL %s_done_pulses got %0d want 1", tag, pulses);
        end
        n_vec++;
        if (cfg_busy !== 1'b0) begin
            n_miss++; $display("FAIL %s_busy_after got %b want 0", tag, cfg_busy);
        end
    endtask

    task automatic test_restart();
        int early;
        early     = 0;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b0;
            step();
            if (cfg_done === 1'b1) early++;
        end
        cfg_valid = 1'b0;
        n_vec++;
        if (early != 0) begin
            n_miss++; $display("FAIL restart_partial_done got %0d want 0", early);
        end
        load_table(8'hFF, 3'd5, "restart");
        test_sweep("sweep_ff");
    endtask

    task automatic test_reset_mid_load();
        logic e;
        load_table(8'h96, 3'd1, "reload96");
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        rst  = 1'b0;
        tbl  = 8'h45;
        tbl2 = 8'h45;
        q.delete();
        n_vec++;
        if (cfg_busy !== 1'b0) begin
            n_miss++; $display("FAIL midrst_busy got %b want 0", cfg_busy);
        end
        in_valid = 1'b1;
        in_vec   = 3'd6;
        q.push_back(tbl[6]);
        step();
        in_valid = 1'b0;
        e = q.pop_front();
        n_vec++;
        if (f !== e) begin
            n_miss++; $display("FAIL midrst_f6 got %b want %b", f, e);
        end
        test_sweep("sweep_init_again");
    endtask

    task automatic test_two_channel();
        logic [7:0] bits;
        logic [1:0] e;
        int         order[4];
        bits       = 8'b0110_1000;
        order      = '{3, 1, 0, 2};
        cfg_start2 = 1'b1;
        step();
        cfg_start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_valid2 = 1'b1;
            cfg_bit2   = bits[i];
            step();
        end
        cfg_valid2 = 1'b0;
        n_vec++;
        if (cfg_done2 !== 1'b1) begin
            n_miss++; $display("FAIL ch2_done got %b want 1", cfg_done2);
        end
        step();
        tbl2 = bits;
        for (int j = 0; j < 4; j++) begin
            in_valid2 = 1'b1;
            in_vec2   = 2'(order[j]);
            q2.push_back({tbl2[4 + order[j]], tbl2[order[j]]});
            step();
            e = q2.pop_front();
            n_vec++;
            if (out_valid2 !== 1'b1 || f2 !== e) begin
                n_miss++;
                $display("FAIL ch2_f v=%0d got valid=%b f=%b want valid=1 f=%b", order[j], out_valid2, f2, e);
            end
        end
        in_valid2 = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0; in_vec  = '0;
        cfg_start  = 1'b0; cfg_valid  = 1'b0; cfg_bit  = 1'b0;
        in_valid2  = 1'b0; in_vec2 = '0;
        cfg_start2 = 1'b0; cfg_valid2 = 1'b0; cfg_bit2 = 1'b0;
        tbl  = 8'h45;
        tbl2 = 8'h45;

        test_reset();
        test_sweep("sweep_init");
        load_table(8'h96, 3'd1, "load96");
        test_sweep("sweep_96");
        test_restart();
        test_reset_mid_load();
        test_two_channel();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
